mult_control: RTL and testbench

- Sequencing controller for the shift-add signed multiplier datapath (X/A/B registers, 9-bit adder/subtractor).
- Sits directly downstream of the board-level run and load/clear inputs, and directly upstream of the register and adder control pins.
- Converts a run level into one complete multiply pass: clear XA, then WIDTH add/sub-then-shift iterations, then a hold until run is released.
- Also gates the load-B/clear request so it is never honoured mid-multiply.

---
 rtl/mult_control.sv | 133 +++++++++++++
 tb/tb_mult_control.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_control.sv
// Sequencing controller for a shift-add signed multiplier datapath.
// A rising edge on run_i (seen in IDLE or DONE) launches one fixed-length pass:
// one clear cycle, then WIDTH add/sub-then-shift iterations, then DONE until
// the next rising edge. The load/clear request is only honoured while no pass
// is in flight.
module mult_control #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_i,
  input  logic          load_clr_i,
  input  logic          m_i,
  output logic          clr_xa,
  output logic          ld_b,
  output logic          add,
  output logic          sub,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t        state_q;
  logic [CW-1:0] iter_q;
  logic          run_q;
  logic          idle_or_done_s;
  logic          start_s;
  logic          last_iter_s;

  assign idle_or_done_s = (state_q == S_IDLE) || (state_q == S_DONE);
  // run_q comes out of reset high, so a run level held through reset is not an edge
  assign start_s        = run_i & ~run_q & idle_or_done_s;
  assign last_iter_s    = (iter_q == LAST_ITER);

  // Pass sequencer: state, iteration counter and run edge history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      run_q   <= 1'b1;
    end else begin
      run_q <= run_i;
      case (state_q)
        S_IDLE: begin
          if (start_s) state_q <= S_CLR;
          else         state_q <= S_IDLE;
        end
        S_CLR: begin
          iter_q  <= '0;
          state_q <= S_ADD;
        end
        S_ADD: begin
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (last_iter_s) begin
            state_q <= S_DONE;
          end else begin
            iter_q  <= iter_q + CW'(1);
            state_q <= S_ADD;
          end
        end
        S_DONE: begin
          // iter keeps WIDTH-1 here; only a fresh run edge leaves DONE
          if (start_s) state_q <= S_CLR;
          else         state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          iter_q  <= '0;
        end
      endcase
    end
  end

  // Strobe decode from state; add/sub follow m_i directly, everything is forced low during reset
  always_comb begin
    clr_xa = 1'b0;
    ld_b   = 1'b0;
    add    = 1'b0;
    sub    = 1'b0;
    shift  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    iter   = '0;
    if (!reset) begin
      iter = iter_q;
      case (state_q)
        S_IDLE: begin
          ld_b   = load_clr_i;
          clr_xa = load_clr_i;
        end
        S_CLR: begin
          clr_xa = 1'b1;
          busy   = 1'b1;
        end
        S_ADD: begin
          busy = 1'b1;
          // the final (sign) bit of the multiplier carries negative weight
          add  = m_i & ~last_iter_s;
          sub  = m_i & last_iter_s;
        end
        S_SHIFT: begin
          shift = 1'b1;
          busy  = 1'b1;
        end
        S_DONE: begin
          done   = 1'b1;
          ld_b   = load_clr_i;
          clr_xa = load_clr_i;
        end
        default: begin
          clr_xa = 1'b0;
        end
      endcase
    end else begin
      iter = '0;
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// Directed self-checking bench for mult_control (WIDTH=8).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mult_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_i;
  logic       load_clr_i;
  logic       m_i;
  logic       clr_xa, ld_b, add, sub, shift, busy, done;
  logic [2:0] iter;

  int checks   = 0;
  int failures = 0;

  mult_control #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .run_i      (run_i),
    .load_clr_i (load_clr_i),
    .m_i        (m_i),
    .clr_xa     (clr_xa),
    .ld_b       (ld_b),
    .add        (add),
    .sub        (sub),
    .shift      (shift),
    .busy       (busy),
    .done       (done),
    .iter       (iter)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Three reset cycles then ten quiet idle cycles: every output low, iter 0
  task automatic test_reset();
    logic [6:0] got;
    reset = 1'b1; run_i = 1'b0; load_clr_i = 1'b0; m_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      got = {clr_xa, ld_b, add, sub, shift, busy, done};
      checks++;
      if (got !== 7'b0 || iter !== 3'd0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b iter=%0d exp=0000000 iter=0", i, got, iter);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); m_i = i[0]; #1;
      got = {clr_xa, ld_b, add, sub, shift, busy, done};
      checks++;
      if (got !== 7'b0 || iter !== 3'd0) begin
        failures++;
        $display("FAIL idle_quiet cyc=%0d got=%b iter=%0d exp=0000000 iter=0", i, got, iter);
      end
    end
  endtask

  // Load/clear in IDLE asserts ld_b and clr_xa as a level, without starting anything
  task automatic test_load_idle();
    for (int i = 0; i < 2; i++) begin
      load_clr_i = 1'b1; #1;
      checks++;
      if ({ld_b, clr_xa, busy, done} !== 4'b1100) begin
        failures++;
        $display("FAIL load_idle cyc=%0d got ld_b,clr,busy,done=%b exp=1100", i, {ld_b, clr_xa, busy, done});
      end
      step();
    end
    load_clr_i = 1'b0; #1;
    checks++;
    if ({ld_b, clr_xa, busy} !== 3'b000) begin
      failures++;
      $display("FAIL load_idle_release got ld_b,clr,busy=%b exp=000", {ld_b, clr_xa, busy});
    end
  endtask

  // Full pass: run_i must already be low. mode 0 plain, 1 toggle run_i while busy,
  // 2 hold load_clr_i while busy, 3 raise load_clr_i together with the run edge.
  // m_i follows multiplier b in ADD cycles and is driven high elsewhere.
  task automatic run_pass(input logic [7:0] b, input int mode, input int exp_add, input int exp_sub);
    logic [6:0] got, exp;
    int         n_add, n_sub, n_shift, k;
    logic       even;
    n_add = 0; n_sub = 0; n_shift = 0;
    step();
    run_i = 1'b1; load_clr_i = (mode == 3); m_i = 1'b1; #1;
    checks++;
    exp = {(mode == 3), (mode == 3), 5'b00000};
    got = {clr_xa, ld_b, add, sub, shift, busy, 1'b0};
    if (got !== exp) begin
      failures++;
      $display("FAIL pass_start mode=%0d got=%b exp=%b", mode, got, exp);
    end
    for (int c = 1; c <= 17; c++) begin
      step();
      k    = (c >= 2) ? (c - 2) / 2 : 0;
      even = (c >= 2) && (c % 2 == 0);
      m_i  = even ? b[k] : 1'b1;
      load_clr_i = (mode == 2);
      if (mode == 1) run_i = ~run_i;
      #1;
      exp = {(c == 1), 1'b0, even && b[k] && (k != 7), even && b[k] && (k == 7),
             (c >= 3) && (c % 2 == 1), 1'b1, 1'b0};
      got = {clr_xa, ld_b, add, sub, shift, busy, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pass_seq b=%h mode=%0d cyc=%0d got=%b exp=%b", b, mode, c, got, exp);
      end
      if (c >= 2) begin
        checks++;
        if (iter !== k[2:0]) begin
          failures++;
          $display("FAIL pass_iter b=%h cyc=%0d got=%0d exp=%0d", b, c, iter, k);
        end
      end
      n_add   += int'(add);
      n_sub   += int'(sub);
      n_shift += int'(shift);
    end
    step();
    m_i = 1'b0; load_clr_i = 1'b0; #1;
    checks++;
    got = {clr_xa, ld_b, add, sub, shift, busy, done};
    if (got !== 7'b0000001 || iter !== 3'd7) begin
      failures++;
      $display("FAIL pass_done b=%h got=%b iter=%0d exp=0000001 iter=7", b, got, iter);
    end
    checks++;
    if (n_add != exp_add || n_sub != exp_sub || n_shift != 8) begin
      failures++;
      $display("FAIL pass_counts b=%h add=%0d sub=%0d shift=%0d exp add=%0d sub=%0d shift=8",
               b, n_add, n_sub, n_shift, exp_add, exp_sub);
    end
  endtask

  // m_i=1 throughout: seven adds, one sub on the last iteration, eight shifts
  task automatic test_single_pass();
    run_i = 1'b0;
    run_pass(8'hFF, 0, 7, 1);
  endtask

  // run_i still high in DONE must not start another pass
  task automatic test_keep_run_high();
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      checks++;
      if ({done, busy, clr_xa, iter} !== {3'b100, 3'd7}) begin
        failures++;
        $display("FAIL hold_done cyc=%0d got done,busy,clr=%b iter=%0d exp=100 iter=7", i, {done, busy, clr_xa}, iter);
      end
    end
  endtask

  // Drop run_i for two cycles then raise; B=0000_0101 gives adds in iterations 0 and 2
  task automatic test_retrigger_data();
    run_i = 1'b0;
    step(); #1;
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL run_low_done got done,busy=%b exp=10", {done, busy});
    end
    run_pass(8'h05, 0, 2, 0);
  endtask

  // run_i toggling during busy has no effect; B=1000_0001 gives one add and one sub
  task automatic test_toggle_run();
    run_i = 1'b0;
    run_pass(8'h81, 1, 1, 1);
  endtask

  // load_clr_i held during busy produces no ld_b and an unchanged strobe sequence
  task automatic test_load_busy();
    run_i = 1'b0;
    run_pass(8'hFF, 2, 7, 1);
  endtask

  // Load request plus run edge in DONE: ld_b that cycle, CLR next; B=0011_1100 gives four adds
  task automatic test_load_with_start();
    run_i = 1'b0;
    run_pass(8'h3C, 3, 4, 0);
  endtask

  // Reset during iteration 3 SHIFT; a run level held across reset must not start a pass
  task automatic test_reset_mid_pass();
    logic [6:0] got;
    run_i = 1'b0;
    step();
    run_i = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step(); m_i = 1'b1;
    end
    #1;
    checks++;
    if (shift !== 1'b1 || iter !== 3'd3) begin
      failures++;
      $display("FAIL mid_pass_pos got shift=%b iter=%0d exp shift=1 iter=3", shift, iter);
    end
    reset = 1'b1; #1;
    got = {clr_xa, ld_b, add, sub, shift, busy, done};
    checks++;
    if (got !== 7'b0) begin
      failures++;
      $display("FAIL reset_gates got=%b exp=0000000", got);
    end
    step();
    reset = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      got = {clr_xa, ld_b, add, sub, shift, busy, done};
      checks++;
      if (got !== 7'b0 || iter !== 3'd0) begin
        failures++;
        $display("FAIL post_reset_idle cyc=%0d got=%b iter=%0d exp=0000000 iter=0", i, got, iter);
      end
      step(); #1;
    end
    run_i = 1'b0;
    run_pass(8'h01, 0, 1, 0);
  endtask

  initial begin
    reset = 1'b1; run_i = 1'b0; load_clr_i = 1'b0; m_i = 1'b0;
    test_reset();
    test_load_idle();
    test_single_pass();
    test_keep_run_high();
    test_retrigger_data();
    test_toggle_run();
    test_load_busy();
    test_load_with_start();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
